// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: splits RISC-V loads/stores into byte transactions
// on a one-byte memory port and reassembles/extends load data.
module mem_byte_sequencer #(
  parameter int ADDR_W = 32,
  parameter bit GAP_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ready_i
);

  typedef enum logic [1:0] {
    IDLE, REQ, GAP, RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [31:0]         wdata_q;
  logic [31:0]         asm_q;
  logic [1:0]          idx_q;
  logic [1:0]          last_q;
  logic                err_q;
  logic                legal;
  logic [1:0]          last_d;
  logic                accept;
  logic                last_byte;

  always_comb begin
    legal = 1'b0;
    unique case (req_funct3_i)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = ~req_we_i;
      default:          legal = 1'b0;
    endcase
  end

  // byte count minus one: b/bu -> 0, h/hu -> 1, w -> 3
  always_comb begin
    last_d = 2'd0;
    unique case (req_funct3_i[1:0])
      2'd1:    last_d = 2'd1;
      2'd2:    last_d = 2'd3;
      default: last_d = 2'd0;
    endcase
  end

  assign accept    = (state_q == IDLE) && req_valid_i;
  assign last_byte = (idx_q == last_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      wdata_q <= '0;
      asm_q   <= '0;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q  <= req_addr_i;
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        wdata_q <= req_wdata_i;
        asm_q   <= '0;
        idx_q   <= 2'd0;
        last_q  <= last_d;
        err_q   <= ~legal;
      end else if (state_q == REQ && mem_ready_i) begin
        if (!we_q) asm_q[8*idx_q +: 8] <= mem_rdata_i[7:0];
        if (!last_byte) idx_q <= idx_q + 2'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_rdata_o  = '0;
    rsp_err_o    = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_write_o  = 1'b0;
    mem_read_o   = 1'b0;
    mem_funct3_o = 3'b100;
    busy_o       = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = legal ? REQ : RESP;
      end
      REQ: begin
        mem_addr_o  = base_q + ADDR_W'(idx_q);
        mem_wdata_o = {24'b0, wdata_q[8*idx_q +: 8]};
        mem_write_o = we_q;
        mem_read_o  = ~we_q;
        if (mem_ready_i) begin
          if (last_byte)   state_d = RESP;
          else if (GAP_EN) state_d = GAP;
          else             state_d = REQ;
        end
      end
      GAP: state_d = REQ;
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        if (!err_q && !we_q) begin
          unique case (f3_q)
            3'd0:    rsp_rdata_o = {{24{asm_q[7]}}, asm_q[7:0]};
            3'd1:    rsp_rdata_o = {{16{asm_q[15]}}, asm_q[15:0]};
            3'd2:    rsp_rdata_o = asm_q;
            3'd4:    rsp_rdata_o = {24'b0, asm_q[7:0]};
            3'd5:    rsp_rdata_o = {16'b0, asm_q[15:0]};
            default: rsp_rdata_o = '0;
          endcase
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb_mem_byte_sequencer: scoreboard bench with a byte-memory responder
// and a response monitor decoupled from the stimulus.
module tb_mem_byte_sequencer;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [2:0]    mem_funct3;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ready;
  logic          rdy_r = 1'b0;
  logic          spur = 1'b0;

  assign mem_ready = rdy_r | spur;

  always #5 clk = ~clk;

  mem_byte_sequencer #(.ADDR_W(AW), .GAP_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(req_funct3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .busy_o(busy),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_write_o(mem_write), .mem_read_o(mem_read),
    .mem_funct3_o(mem_funct3), .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [7:0]    b;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } rsp_t;

  txn_t txn_q[$];
  rsp_t rsp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  int done_cnt = 0;
  int stall = 0;

  task automatic chk(input string n, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic push_t(input logic [AW-1:0] a, input logic we,
                        input logic [7:0] b);
    txn_t t;
    t.addr = a; t.we = we; t.b = b;
    txn_q.push_back(t);
  endtask

  task automatic push_r(input logic [31:0] d, input logic e,
                        input int lat);
    rsp_t r;
    r.data = d; r.err = e; r.lat = lat;
    rsp_q.push_back(r);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid) begin
      if (rsp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
      else begin
        e = rsp_q.pop_front();
        chk("rsp_data", rsp_rdata, e.data);
        chk("rsp_err", rsp_err, e.err);
        if (e.lat >= 0) chk("rsp_lat", cyc - acc, e.lat);
      end
    end
  end

  // byte memory responder
  initial begin
    txn_t e;
    logic [95:0] snap;
    forever begin
      @(negedge clk);
      rdy_r = 1'b0;
      if (rst_n && (mem_read || mem_write)) begin
        if (txn_q.size() == 0)
          chk("unexpected_txn", {mem_read, mem_write}, 0);
        else begin
          e = txn_q.pop_front();
          chk("txn_addr", mem_addr, e.addr);
          chk("txn_we", mem_write, e.we);
          chk("txn_rd", mem_read, !e.we);
          chk("txn_funct3", mem_funct3, 3'b100);
          if (e.we) chk("txn_wdata", mem_wdata, {24'b0, e.b});
          snap = {mem_addr, mem_wdata, mem_read, mem_write};
          for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!rst_n) break;
            chk("stall_hold",
                {mem_addr, mem_wdata, mem_read, mem_write}, snap);
          end
          if (rst_n) begin
            mem_rdata = {24'hA55AC3, e.b};
            rdy_r = 1'b1;
            done_cnt++;
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [AW-1:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    if (!req_ready) chk("accept_timeout", req_ready, 1);
    acc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || txn_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("timeout", rsp_q.size() + txn_q.size(), 0);
      rsp_q.delete();
      txn_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("reset_ctl",
        {req_ready, busy, rsp_valid, mem_read, mem_write, mem_funct3},
        8'b1000_0100);
    chk("reset_zero", {rsp_rdata, mem_wdata, mem_addr}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push_t(32'h100, 0, 8'h78); push_t(32'h101, 0, 8'h56);
    push_t(32'h102, 0, 8'h34); push_t(32'h103, 0, 8'h12);
    push_r(32'h12345678, 0, 8);
    issue(0, 3'd2, 32'h100, 0); wait_done();

    push_t(32'h40, 0, 8'h01); push_t(32'h41, 0, 8'h80);
    push_r(32'hFFFF8001, 0, -1);
    issue(0, 3'd1, 32'h40, 0); wait_done();

    push_t(32'h40, 0, 8'h01); push_t(32'h41, 0, 8'h80);
    push_r(32'h00008001, 0, -1);
    issue(0, 3'd5, 32'h40, 0); wait_done();

    push_t(32'h41, 0, 8'h80);
    push_r(32'hFFFFFF80, 0, 2);
    issue(0, 3'd0, 32'h41, 0); wait_done();

    push_t(32'h203, 1, 8'hEF); push_t(32'h204, 1, 8'hBE);
    push_t(32'h205, 1, 8'hAD); push_t(32'h206, 1, 8'hDE);
    push_r(32'h0, 0, 8);
    issue(1, 3'd2, 32'h203, 32'hDEADBEEF); wait_done();

    push_t(32'hFFFFFFFE, 0, 8'h11); push_t(32'hFFFFFFFF, 0, 8'h22);
    push_t(32'h0, 0, 8'h33); push_t(32'h1, 0, 8'h44);
    push_r(32'h44332211, 0, -1);
    issue(0, 3'd2, 32'hFFFFFFFE, 0); wait_done();

    push_r(32'h0, 1, 1);
    issue(0, 3'd3, 32'h80, 0); wait_done();
    push_r(32'h0, 1, 1);
    issue(1, 3'd4, 32'h80, 32'h55); wait_done();

    stall = 5;
    push_t(32'h10, 1, 8'hC3); push_t(32'h11, 1, 8'hA5);
    push_r(32'h0, 0, -1);
    issue(1, 3'd1, 32'h10, 32'h1234A5C3); wait_done();
    push_t(32'h20, 0, 8'hF0);
    push_r(32'h000000F0, 0, 7);
    issue(0, 3'd4, 32'h20, 0); wait_done();
    stall = 0;

    @(negedge clk); spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spur_idle_busy", busy, 0);
    end
    spur = 1'b0;
    repeat (2) @(negedge clk);

    k = done_cnt + 2;
    push_t(32'h300, 0, 8'hAA); push_t(32'h301, 0, 8'hBB);
    issue(0, 3'd2, 32'h300, 0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (done_cnt >= k) break;
    end
    chk("reset_prep", done_cnt, k);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctl",
        {req_ready, busy, rsp_valid, mem_read, mem_write, mem_funct3},
        8'b1000_0100);
    chk("abort_zero", {rsp_rdata, mem_wdata, mem_addr}, 0);
    @(negedge clk); spur = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); spur = 1'b0;
    chk("abort_idle_busy", busy, 0);
    txn_q.delete();
    repeat (2) @(negedge clk);

    push_t(32'h500, 0, 8'h7F);
    push_r(32'h0000007F, 0, 2);
    issue(0, 3'd0, 32'h500, 0); wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
